// File: rtl/alu_issue_queue.sv
// Decodes ALUOp/funct into a 4-bit ALU control and queues {control, src1, src2}; `ALU_ISSUE_ILLEGAL_CNT_EN enables illegal_cnt.
// Head appears the cycle after push (no bypass); in_ready drops when full, head held stable while out_ready is low.
module alu_issue_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [1:0]                   in_aluop,
   input  logic [5:0]                   in_funct,
   input  logic [31:0]                  in_src1,
   input  logic [31:0]                  in_src2,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CW-1:0]                out_control,
   output logic [31:0]                  out_src1,
   output logic [31:0]                  out_src2,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic [7:0]                   illegal_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [CW-1:0] control;
      logic [31:0]   src1;
      logic [31:0]   src2;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] dec_control;
   logic          push;
   logic          pop;

   always_comb begin
      dec_control = CW'(4'b1111);
      case (in_aluop)
         2'b00: dec_control = CW'(4'b0010);
         2'b01: dec_control = CW'(4'b0110);
         2'b11: dec_control = CW'(4'b0111);
         default: begin
            case (in_funct)
               6'b100000: dec_control = CW'(4'b0010);
               6'b100010: dec_control = CW'(4'b0110);
               6'b100100: dec_control = CW'(4'b0000);
               6'b100101: dec_control = CW'(4'b0001);
               6'b100111: dec_control = CW'(4'b1100);
               6'b101010: dec_control = CW'(4'b0111);
               default:   dec_control = CW'(4'b1111);
            endcase
         end
      endcase
   end

   assign in_ready  = (level != LW'(DEPTH));
   assign out_valid = (level != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Storage needs no reset: level gates everything visible at the head.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= '{control: dec_control, src1: in_src1, src2: in_src2};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   assign head        = mem[rd_ptr];
   assign out_control = out_valid ? head.control : '0;
   assign out_src1    = out_valid ? head.src1    : '0;
   assign out_src2    = out_valid ? head.src2    : '0;

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
   logic [7:0] illegal_q;
   logic       dec_illegal;

   // Only R-type can decode to 1111, but keep the aluop qualifier explicit.
   assign dec_illegal = (in_aluop == 2'b10) && (dec_control == CW'(4'b1111));

   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_q <= 8'd0;
      end else if (push && dec_illegal && illegal_q != 8'hFF) begin
         illegal_q <= illegal_q + 8'd1;
      end
   end

   assign illegal_cnt = illegal_q;
`else
   assign illegal_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: expected entries queued on accepted pushes, compared at the head on pops.
module tb_alu_issue_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_aluop = 2'b00;
   logic [5:0]  in_funct = 6'd0;
   logic [31:0] in_src1 = 32'd0;
   logic [31:0] in_src2 = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_control;
   logic [31:0] out_src1;
   logic [31:0] out_src2;
   logic [2:0]  level;
   logic [7:0]  illegal_cnt;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_ill  = 0;
   int   n;
   logic [5:0] rfun [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
   logic [5:0] bad  [4] = '{6'b111111, 6'b000000, 6'b100001, 6'b101011};

   alu_issue_queue #(.DEPTH(DEPTH), .CW(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_aluop(in_aluop), .in_funct(in_funct),
      .in_src1(in_src1), .in_src2(in_src2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_control(out_control), .out_src1(out_src1), .out_src2(out_src2),
      .level(level), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_ctrl(input logic [1:0] op, input logic [5:0] f);
      if (op == 2'b00) return 4'b0010;
      if (op == 2'b01) return 4'b0110;
      if (op == 2'b11) return 4'b0111;
      if (f == 6'b100000) return 4'b0010;
      if (f == 6'b100010) return 4'b0110;
      if (f == 6'b100100) return 4'b0000;
      if (f == 6'b100101) return 4'b0001;
      if (f == 6'b100111) return 4'b1100;
      if (f == 6'b101010) return 4'b0111;
      return 4'b1111;
   endfunction

   function automatic int exp_ill_cnt();
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
      return m_ill;
`else
      return 0;
`endif
   endfunction

   // Reference model: occupancy is the scoreboard size.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         m_ill = 0;
      end else begin
         n = sb.size();
         check_eq("in_ready", in_ready, n != DEPTH);
         check_eq("out_valid", out_valid, n != 0);
         check_eq("level", level, n);
         check_eq("illegal_cnt", illegal_cnt, exp_ill_cnt());
         if (n != 0) begin
            check_eq("out_control", out_control, sb[0].ctrl);
            check_eq("out_src1", out_src1, sb[0].a);
            check_eq("out_src2", out_src2, sb[0].b);
            if (out_ready) void'(sb.pop_front());
         end else begin
            check_eq("idle_control", out_control, 0);
            check_eq("idle_src1", out_src1, 0);
            check_eq("idle_src2", out_src2, 0);
         end
         if (in_valid && n != DEPTH) begin
            sb.push_back('{exp_ctrl(in_aluop, in_funct), in_src1, in_src2});
            if (exp_ctrl(in_aluop, in_funct) == 4'b1111 && in_aluop == 2'b10 && m_ill != 255)
               m_ill++;
         end
      end
   end

   task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      in_aluop = op;
      in_funct = f;
      in_src1  = a;
      in_src2  = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check_eq("drain_empty", sb.size(), 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_level", level, 0);
      check_eq("rst_src1", out_src1, 0);

      // First entry visible the cycle after the push.
      @(posedge clk); #1;
      drive(2'b10, 6'b100010, 32'd7, 32'd3);
      @(negedge clk);
      check_eq("first_ctrl", out_control, 4'b0110);
      check_eq("first_src1", out_src1, 32'd7);
      check_eq("first_src2", out_src2, 32'd3);
      @(posedge clk); #1;
      drain();

      // Every decode case, issued back to back.
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) drive(2'b10, rfun[i], 32'(i), $urandom);
      drive(2'b00, 6'b111111, 32'd6, $urandom);
      drive(2'b01, 6'b000000, 32'd7, $urandom);
      drive(2'b11, 6'b101010, 32'd8, $urandom);
      drain();

      // Fill, try a dropped push, then a full-with-pop push that must also be ignored.
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) drive(2'b00, 6'd0, 32'(i), 32'(i * 16));
      @(negedge clk);
      check_eq("full_level", level, 4);
      check_eq("full_in_ready", in_ready, 0);
      @(posedge clk); #1;
      drive(2'b00, 6'd0, 32'd5, 32'd5);
      out_ready = 1'b1;
      drive(2'b01, 6'd0, 32'd6, 32'd6);
      drain();

      // Steady state at level 2 with simultaneous push and pop.
      out_ready = 1'b0;
      drive(2'b00, 6'd0, 32'hA0, 32'd0);
      drive(2'b11, 6'd0, 32'hA1, 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) drive(2'b10, rfun[i % 6], 32'h100 + 32'(i), $urandom);
      @(negedge clk);
      check_eq("steady_level", level, 2);
      @(posedge clk); #1;
      drain();

      // Illegal functs, including counter saturation.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) drive(2'b10, 6'b111111, 32'(i), 32'(i));
      @(negedge clk);
      check_eq("ill3", illegal_cnt, exp_ill_cnt());
      @(posedge clk); #1;
      for (int i = 0; i < 300; i++) drive(2'b10, bad[i % 4], $urandom, $urandom);
      @(negedge clk);
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
      check_eq("ill_sat", illegal_cnt, 255);
`else
      check_eq("ill_off", illegal_cnt, 0);
`endif
      @(posedge clk); #1;
      drain();

      // Reset beats a concurrent push and pop.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) drive(2'b10, 6'b111111, 32'(i), 32'(i));
      rst = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check_eq("rst_flush_level", level, 0);
      check_eq("rst_flush_valid", out_valid, 0);
      check_eq("rst_flush_ill", illegal_cnt, 0);
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
